// File: rtl/lvds_word_fifo.sv
// lvds_word_fifo: packs receiver bytes LSB-first into words and buffers them
// in a first-word-fall-through FIFO whose head sits in a registered o_data.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   i_byte            received byte, qualified by i_byte_valid
//   i_frame_start     realigns the packer to byte 0, dropping a partial word
//   i_fifo_en         one-cycle read pulse, pops the head word
//   o_data, o_empty   head word and its (inverted) valid
//   o_full, o_level   occupancy, counting the output register
//   o_overflow        sticky, a completed word was dropped
//   o_underflow       sticky, a read arrived while empty
//   i_clr_flags       clears both sticky flags
module lvds_word_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_WIDTH-1:0] i_byte,
  input  logic                  i_byte_valid,
  input  logic                  i_frame_start,
  input  logic                  i_fifo_en,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_overflow,
  output logic                  o_underflow,
  input  logic                  i_clr_flags
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [IW-1:0]         idx;
  logic [IW-1:0]         eff_idx;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
  logic                  word_done;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   ram_count;
  logic                  out_valid;

  logic pop;
  logic wr;
  logic load;
  logic ovf_set;
  logic unf_set;

  // Packer: frame_start forces this cycle's byte into lane 0.
  always_comb begin
    eff_idx  = i_frame_start ? '0 : idx;
    acc_next = acc;
    for (int b = 0; b < NB; b++) begin
      if (eff_idx == IW'(b)) begin
        acc_next[b*BYTE_WIDTH +: BYTE_WIDTH] = i_byte;
      end
    end
    word_done = i_byte_valid && (eff_idx == IW'(NB - 1));
  end

  assign o_level = ram_count + {{ADDR_WIDTH{1'b0}}, out_valid};
  assign o_full  = (o_level == (ADDR_WIDTH+1)'(DEPTH));
  assign o_empty = !out_valid;

  // A same-cycle write never feeds the head register directly: it lands in
  // RAM first, so a pop while empty is an underflow even if a word arrives.
  assign pop     = i_fifo_en && out_valid;
  assign wr      = word_done && (!o_full || pop);
  assign load    = (ram_count != '0) && (!out_valid || pop);
  assign ovf_set = word_done && o_full && !pop;
  assign unf_set = i_fifo_en && !out_valid;

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr] <= acc_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      acc         <= '0;
      wptr        <= '0;
      rptr        <= '0;
      ram_count   <= '0;
      out_valid   <= 1'b0;
      o_data      <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_byte_valid) begin
        acc <= acc_next;
        idx <= word_done ? '0 : eff_idx + IW'(1);
      end else if (i_frame_start) begin
        idx <= '0;
      end

      if (wr) begin
        wptr <= wptr + ADDR_WIDTH'(1);
      end
      if (load) begin
        rptr   <= rptr + ADDR_WIDTH'(1);
        o_data <= mem[rptr];
      end

      case ({wr, load})
        2'b10:   ram_count <= ram_count + (ADDR_WIDTH+1)'(1);
        2'b01:   ram_count <= ram_count - (ADDR_WIDTH+1)'(1);
        default: ram_count <= ram_count;
      endcase

      if (load) begin
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end

      o_overflow  <= ovf_set || (o_overflow && !i_clr_flags);
      o_underflow <= unf_set || (o_underflow && !i_clr_flags);
    end
  end

endmodule

// File: tb/tb_lvds_word_fifo.sv
// tb_lvds_word_fifo: directed checks of packing, FWFT latency, full/overflow,
// underflow, sticky-flag clearing and mid-stream reset.
module tb_lvds_word_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        i_frame_start;
  logic        i_fifo_en;
  logic [31:0] o_data;
  logic        o_empty;
  logic        o_full;
  logic [9:0]  o_level;
  logic        o_overflow;
  logic        o_underflow;
  logic        i_clr_flags;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lvds_word_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .i_byte        (i_byte),
    .i_byte_valid  (i_byte_valid),
    .i_frame_start (i_frame_start),
    .i_fifo_en     (i_fifo_en),
    .o_data        (o_data),
    .o_empty       (o_empty),
    .o_full        (o_full),
    .o_level       (o_level),
    .o_overflow    (o_overflow),
    .o_underflow   (o_underflow),
    .i_clr_flags   (i_clr_flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_byte       = b;
    i_byte_valid = 1'b1;
    tick();
    i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      send_byte(w[8*b +: 8]);
    end
  endtask

  task automatic pop();
    i_fifo_en = 1'b1;
    tick();
    i_fifo_en = 1'b0;
  endtask

  function automatic logic [31:0] wk(input int k);
    logic [15:0] lo;
    lo = 16'(k);
    return {8'h5A, 8'hA5, lo};
  endfunction

  initial begin
    rst           = 1'b1;
    i_byte        = '0;
    i_byte_valid  = 1'b0;
    i_frame_start = 1'b0;
    i_fifo_en     = 1'b0;
    i_clr_flags   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_data", o_data, 32'h0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_unf", 32'(o_underflow), 32'd0);

    // basic packing and FWFT latency
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("lat_empty_n", 32'(o_empty), 32'd1);
    chk("lat_level_n", 32'(o_level), 32'd1);
    tick();
    chk("pk_data", o_data, 32'h44332211);
    chk("pk_empty", 32'(o_empty), 32'd0);
    chk("pk_level", 32'(o_level), 32'd1);

    // reset mid-stream with a stored word and a partial word
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_data", o_data, 32'h0);
    chk("mrst_empty", 32'(o_empty), 32'd1);
    chk("mrst_level", 32'(o_level), 32'd0);
    chk("mrst_full", 32'(o_full), 32'd0);
    send_word(32'hC4C3C2C1);
    tick();
    chk("mrst_word", o_data, 32'hC4C3C2C1);
    chk("mrst_lvl1", 32'(o_level), 32'd1);
    pop();
    chk("pop1_empty", 32'(o_empty), 32'd1);
    chk("pop1_hold", o_data, 32'hC4C3C2C1);
    chk("pop1_unf", 32'(o_underflow), 32'd0);

    // frame_start realign
    send_byte(8'hAA);
    send_byte(8'hBB);
    i_frame_start = 1'b1;
    send_byte(8'h01);
    i_frame_start = 1'b0;
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    tick();
    chk("fs_data", o_data, 32'h04030201);
    chk("fs_level", 32'(o_level), 32'd1);
    chk("fs_ovf", 32'(o_overflow), 32'd0);
    pop();
    chk("fs_empty", 32'(o_empty), 32'd1);
    chk("fs_lvl0", 32'(o_level), 32'd0);

    // underflow and sticky clear
    pop();
    chk("unf_set", 32'(o_underflow), 32'd1);
    chk("unf_data", o_data, 32'h04030201);
    chk("unf_lvl", 32'(o_level), 32'd0);
    i_clr_flags = 1'b1;
    tick();
    i_clr_flags = 1'b0;
    chk("unf_clr", 32'(o_underflow), 32'd0);
    i_clr_flags = 1'b1;
    pop();
    i_clr_flags = 1'b0;
    chk("unf_clr_set", 32'(o_underflow), 32'd1);
    i_clr_flags = 1'b1;
    tick();
    i_clr_flags = 1'b0;
    chk("unf_clr2", 32'(o_underflow), 32'd0);

    // fill to full, then one dropped word
    for (int k = 0; k < 512; k++) begin
      send_word(wk(k));
    end
    chk("full_level", 32'(o_level), 32'd512);
    chk("full_flag", 32'(o_full), 32'd1);
    chk("full_ovf0", 32'(o_overflow), 32'd0);
    send_word(wk(512));
    chk("ovf_set", 32'(o_overflow), 32'd1);
    chk("ovf_level", 32'(o_level), 32'd512);
    i_clr_flags = 1'b1;
    tick();
    i_clr_flags = 1'b0;
    chk("ovf_clr", 32'(o_overflow), 32'd0);

    // completing byte and pop in the same cycle at full
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    chk("wp_head", o_data, wk(0));
    i_fifo_en = 1'b1;
    send_byte(8'hDE);
    i_fifo_en = 1'b0;
    chk("wp_ovf", 32'(o_overflow), 32'd0);
    chk("wp_level", 32'(o_level), 32'd512);
    chk("wp_full", 32'(o_full), 32'd1);

    // drain in order at one word per clock
    for (int k = 1; k < 512; k++) begin
      chk("drain_empty", 32'(o_empty), 32'd0);
      chk("drain_data", o_data, wk(k));
      pop();
    end
    chk("drain_last", o_data, 32'hDEADBEEF);
    chk("drain_lvl1", 32'(o_level), 32'd1);
    pop();
    chk("end_empty", 32'(o_empty), 32'd1);
    chk("end_level", 32'(o_level), 32'd0);
    chk("end_hold", o_data, 32'hDEADBEEF);
    chk("end_unf", 32'(o_underflow), 32'd0);
    chk("end_ovf", 32'(o_overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
